// File: rtl/demux4_deser_pkg.sv
// Shared slot definitions for the 4:1 channel mux and its receive-side demux.
package demux_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0] slot_t;

  localparam slot_t SLOT0 = 2'd0;
  localparam slot_t SLOT1 = 2'd1;
  localparam slot_t SLOT2 = 2'd2;
  localparam slot_t SLOT3 = 2'd3;

endpackage

// File: rtl/demux4_deser_slot_cnt4.sv
// Modulo-4 slot counter; clr_i forces the effective slot to 0 before inc_i applies.
module slot_cnt4
  import demux_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  inc_i,
  input  logic  clr_i,
  output slot_t slot_o,
  output logic  wrap_o
);

  slot_t slot_q, slot_d;
  slot_t eslot;

  always_comb begin
    eslot  = clr_i ? SLOT0 : slot_q;
    slot_d = eslot;
    if (inc_i) slot_d = eslot + slot_t'(1);
  end

  // A clear coinciding with an increment lands on slot 1, never wraps.
  assign wrap_o = inc_i && (eslot == SLOT3);
  assign slot_o = slot_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) slot_q <= SLOT0;
    else       slot_q <= slot_d;
  end

endmodule

// File: rtl/demux4_deser.sv
// Recovers four parallel lanes from a slot-rotated serial stream, with frame sync.
module demux4_deser
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_vld,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_vld,
  output logic [1:0]       sel,
  output logic             err
);

  slot_t            slot;
  slot_t            eslot;
  logic             wrap;
  logic [WIDTH-1:0] stage_q [3];
  logic [WIDTH-1:0] stage_d [3];
  logic [WIDTH-1:0] out_q   [4];
  logic [WIDTH-1:0] out_d   [4];
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  slot_cnt4 u_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (in_vld),
    .clr_i  (sync),
    .slot_o (slot),
    .wrap_o (wrap)
  );

  assign eslot = (sync && in_vld) ? SLOT0 : slot;

  always_comb begin
    stage_d = stage_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    // Any sync seen while mid-frame discards the partial frame.
    err_d   = sync && (slot != SLOT0);
    if (wrap) begin
      out_d[0] = stage_q[0];
      out_d[1] = stage_q[1];
      out_d[2] = stage_q[2];
      out_d[3] = in;
      vld_d    = 1'b1;
    end else if (in_vld) begin
      stage_d[eslot] = in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 3; i++) stage_q[i] <= '0;
      for (int unsigned i = 0; i < 4; i++) out_q[i]   <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign out0    = out_q[0];
  assign out1    = out_q[1];
  assign out2    = out_q[2];
  assign out3    = out_q[3];
  assign out_vld = vld_q;
  assign err     = err_q;
  assign sel     = slot;

endmodule

// File: tb/tb_demux4_deser.sv
// Directed bench for demux4_deser at WIDTH=1 and WIDTH=4.
module tb_demux4_deser;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       in1 = 1'b0, vld1 = 1'b0, sync1 = 1'b0;
  logic       a0, a1, a2, a3, aov, aerr;
  logic [1:0] asel;

  logic [3:0] in4 = '0;
  logic       vld4 = 1'b0, sync4 = 1'b0;
  logic [3:0] b0, b1, b2, b3;
  logic       bov, berr;
  logic [1:0] bsel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  demux4_deser #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .in_vld(vld1), .sync(sync1),
    .out0(a0), .out1(a1), .out2(a2), .out3(a3),
    .out_vld(aov), .sel(asel), .err(aerr)
  );

  demux4_deser #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in(in4), .in_vld(vld4), .sync(sync4),
    .out0(b0), .out1(b1), .out2(b2), .out3(b3),
    .out_vld(bov), .sel(bsel), .err(berr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the WIDTH=1 instance and sample #1 after the edge.
  task automatic cyc(input logic v, input logic s, input logic d);
    vld1 = v; sync1 = s; in1 = d;
    @(posedge clk); #1;
    vld1 = 1'b0; sync1 = 1'b0; in1 = 1'b0;
  endtask

  task automatic cyc4(input logic v, input logic [3:0] d);
    vld4 = v; in4 = d;
    @(posedge clk); #1;
    vld4 = 1'b0; in4 = '0;
  endtask

  task automatic chk1(input string tag, input logic [3:0] outs, input logic ov,
                      input logic [1:0] sl, input logic er);
    chk({tag, ".outs"}, {28'd0, a0, a1, a2, a3}, {28'd0, outs});
    chk({tag, ".vld"},  {31'd0, aov},  {31'd0, ov});
    chk({tag, ".sel"},  {30'd0, asel}, {30'd0, sl});
    chk({tag, ".err"},  {31'd0, aerr}, {31'd0, er});
  endtask

  logic [3:0]  vals [8];
  logic [15:0] exp_out;

  initial begin
    vals = '{4'hA, 4'h5, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};

    // Reset
    #12 rst = 1'b0;
    chk1("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    chk("reset.w4", {bov, berr, bsel, b0, b1, b2, b3}, 32'd0);

    // Nominal frame 1,0,1,1
    cyc(1, 1, 1); chk1("nom1", 4'b0000, 0, 2'd1, 0);
    cyc(1, 0, 0); chk1("nom2", 4'b0000, 0, 2'd2, 0);
    cyc(1, 0, 1); chk1("nom3", 4'b0000, 0, 2'd3, 0);
    cyc(1, 0, 1); chk1("nom4", 4'b1011, 1, 2'd0, 0);
    cyc(0, 0, 0); chk1("nomhold", 4'b1011, 0, 2'd0, 0);

    // Same samples with bubbles of 1, 3, 0 cycles
    cyc(1, 1, 1); chk1("bub1", 4'b1011, 0, 2'd1, 0);
    cyc(0, 0, 1); chk1("bubgap1", 4'b1011, 0, 2'd1, 0);
    cyc(1, 0, 0); chk1("bub2", 4'b1011, 0, 2'd2, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1); chk1("bubgap3", 4'b1011, 0, 2'd2, 0);
    end
    cyc(1, 0, 1); chk1("bub3", 4'b1011, 0, 2'd3, 0);
    cyc(1, 0, 1); chk1("bub4", 4'b1011, 1, 2'd0, 0);

    // Mid-frame sync
    cyc(1, 0, 1); chk1("mid1", 4'b1011, 0, 2'd1, 0);
    cyc(1, 0, 1); chk1("mid2", 4'b1011, 0, 2'd2, 0);
    cyc(1, 1, 0); chk1("midsync", 4'b1011, 0, 2'd1, 1);
    cyc(1, 0, 1); chk1("mid3", 4'b1011, 0, 2'd2, 0);
    cyc(1, 0, 1); chk1("mid4", 4'b1011, 0, 2'd3, 0);
    cyc(1, 0, 0); chk1("mid5", 4'b0110, 1, 2'd0, 0);

    // Idle sync at sel 0 then at sel 2
    cyc(0, 1, 0); chk1("idle0", 4'b0110, 0, 2'd0, 0);
    cyc(1, 0, 1); cyc(1, 0, 0); chk1("idlepre", 4'b0110, 0, 2'd2, 0);
    cyc(0, 1, 0); chk1("idle2", 4'b0110, 0, 2'd0, 1);
    cyc(0, 0, 0); chk1("idle2post", 4'b0110, 0, 2'd0, 0);

    // Async reset mid-frame
    cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1);
    chk1("prerst", 4'b0110, 0, 2'd3, 0);
    #2 rst = 1'b1;
    #1 chk1("asyncrst", 4'b0000, 0, 2'd0, 0);
    #1 rst = 1'b0;
    cyc(1, 1, 1); chk1("post1", 4'b0000, 0, 2'd1, 0);
    cyc(1, 0, 1); chk1("post2", 4'b0000, 0, 2'd2, 0);
    cyc(1, 0, 0); chk1("post3", 4'b0000, 0, 2'd3, 0);
    cyc(1, 0, 1); chk1("post4", 4'b1101, 1, 2'd0, 0);

    // Back-to-back frames at WIDTH=4
    for (int i = 1; i <= 8; i++) begin
      cyc4(1, vals[i-1]);
      if (i < 4)      exp_out = 16'h0000;
      else if (i < 8) exp_out = 16'hA5F0;
      else            exp_out = 16'h1234;
      chk($sformatf("b2b%0d.outs", i), {16'd0, b0, b1, b2, b3}, {16'd0, exp_out});
      chk($sformatf("b2b%0d.vld", i), {31'd0, bov}, {31'd0, (i == 4 || i == 8)});
      chk($sformatf("b2b%0d.sel", i), {30'd0, bsel}, 32'(i % 4));
      chk($sformatf("b2b%0d.err", i), {31'd0, berr}, 32'd0);
    end
    cyc4(0, 4'h0);
    chk("b2bhold", {15'd0, bov, b0, b1, b2, b3}, {15'd0, 1'b0, 16'h1234});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
